// File: rtl/dot_sprite_renderer_pkg.sv
// Shared constants and types for the dot sprite renderer.
package dot_sprite_renderer_pkg;

  localparam int DOT_EDGE  = 8;   // unscaled sprite edge in pixels
  localparam int DOT_WIDTH = 8;   // bits per shape row
  localparam int ROW_W     = 3;   // row / column index width
  localparam int SHAPE_W   = 2;
  localparam int SCALE_W   = 2;

  typedef enum logic [SHAPE_W-1:0] {
    SHAPE_FILLED  = 2'd0,
    SHAPE_RING    = 2'd1,
    SHAPE_DIAMOND = 2'd2,
    SHAPE_BOX     = 2'd3
  } shape_e;

  // Descriptor attributes that travel together (origin kept separately
  // because its width depends on the top-level parameters).
  typedef struct packed {
    shape_e             shape;
    logic [SCALE_W-1:0] scale;
    logic               blink;
    logic               visible;
  } desc_attr_t;

  // Clamp a requested scale exponent to the largest supported one.
  function automatic logic [SCALE_W-1:0] clamp_scale(input logic [SCALE_W-1:0] s,
                                                     input int max_log2);
    if (int'(s) > max_log2) return SCALE_W'(max_log2);
    return s;
  endfunction

endpackage

// File: rtl/dot_sprite_renderer_rom.sv
// Combinational shape ROM: 4 shapes x 8 rows of 8 pixels, MSB = leftmost.
module dot_shape_rom
  import dot_sprite_renderer_pkg::*;
(
  input  logic [SHAPE_W-1:0]   shape,
  input  logic [ROW_W-1:0]     row,
  output logic [DOT_WIDTH-1:0] pattern
);

  // Row 0 sits in the top byte of each table word.
  localparam logic [63:0] TBL_FILLED  = 64'h3C7E_FFFF_FFFF_7E3C;
  localparam logic [63:0] TBL_RING    = 64'h3C42_8181_8181_423C;
  localparam logic [63:0] TBL_DIAMOND = 64'h183C_7EFF_FF7E_3C18;
  localparam logic [63:0] TBL_BOX     = 64'hFF81_8181_8181_81FF;

  logic [5:0] sel;

  // Pick the table for the shape, then the byte for the row.
  always_comb begin
    sel     = {~row, 3'b000};
    pattern = '0;
    case (shape_e'(shape))
      SHAPE_FILLED:  pattern = TBL_FILLED[sel +: 8];
      SHAPE_RING:    pattern = TBL_RING[sel +: 8];
      SHAPE_DIAMOND: pattern = TBL_DIAMOND[sel +: 8];
      SHAPE_BOX:     pattern = TBL_BOX[sel +: 8];
      default:       pattern = '0;
    endcase
  end

endmodule

// File: rtl/dot_sprite_renderer.sv
// Two-stage per-pixel sprite renderer. Descriptor is double-buffered and
// only becomes active on frame_start, so a frame is never torn.
module dot_sprite_renderer
  import dot_sprite_renderer_pkg::*;
#(
  parameter int X_WIDTH           = 11,
  parameter int Y_WIDTH           = 10,
  parameter int MAX_SCALE_LOG2    = 3,
  parameter int BLINK_FRAMES_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [X_WIDTH-1:0] pix_x,
  input  logic [Y_WIDTH-1:0] pix_y,
  input  logic               desc_load,
  input  logic [X_WIDTH-1:0] desc_x,
  input  logic [Y_WIDTH-1:0] desc_y,
  input  logic [1:0]         desc_shape,
  input  logic [1:0]         desc_scale,
  input  logic               desc_blink,
  input  logic               desc_visible,
  output logic               out_valid,
  output logic               out_on,
  output logic [X_WIDTH-1:0] out_x,
  output logic [Y_WIDTH-1:0] out_y
);

  localparam int STAGES = 2;

  desc_attr_t                 in_attr, pend_attr, act_attr;
  logic [X_WIDTH-1:0]         pend_x, act_x;
  logic [Y_WIDTH-1:0]         pend_y, act_y;
  logic [BLINK_FRAMES_LOG2:0] blink_cnt;

  // Incoming descriptor with the scale already clamped, shared by the
  // pending write and the load/frame_start bypass.
  always_comb begin
    in_attr = '{shape:   shape_e'(desc_shape),
                scale:   clamp_scale(desc_scale, MAX_SCALE_LOG2),
                blink:   desc_blink,
                visible: desc_visible};
  end

  // Pending/active descriptor registers and the frame blink counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_attr <= '0;
      pend_x    <= '0;
      pend_y    <= '0;
      act_attr  <= '0;
      act_x     <= '0;
      act_y     <= '0;
      blink_cnt <= '0;
    end else begin
      if (desc_load) begin
        pend_attr <= in_attr;
        pend_x    <= desc_x;
        pend_y    <= desc_y;
      end
      if (frame_start) begin
        blink_cnt <= blink_cnt + 1'b1;
        if (desc_load) begin
          act_attr <= in_attr;
          act_x    <= desc_x;
          act_y    <= desc_y;
        end else begin
          act_attr <= pend_attr;
          act_x    <= pend_x;
          act_y    <= pend_y;
        end
      end
    end
  end

  // Stage 1 datapath: one extra bit so a pixel left of / above the origin
  // (or an origin near coordinate max) shows up as negative, not wrapped.
  logic [X_WIDTH:0]   dx, edge_x;
  logic [Y_WIDTH:0]   dy, edge_y;
  logic               blink_dark, hit_n;
  logic [ROW_W-1:0]   row_n, col_n;

  // Bounding-box test and scaled row/column for the current pixel.
  always_comb begin
    dx         = {1'b0, pix_x} - {1'b0, act_x};
    dy         = {1'b0, pix_y} - {1'b0, act_y};
    edge_x     = (X_WIDTH+1)'(DOT_EDGE) << act_attr.scale;
    edge_y     = (Y_WIDTH+1)'(DOT_EDGE) << act_attr.scale;
    blink_dark = act_attr.blink && blink_cnt[BLINK_FRAMES_LOG2];
    hit_n      = !dx[X_WIDTH] && !dy[Y_WIDTH] && (dx < edge_x) && (dy < edge_y) &&
                 act_attr.visible && !blink_dark;
    row_n      = ROW_W'(dy >> act_attr.scale);
    col_n      = ROW_W'(dx >> act_attr.scale);
  end

  logic [STAGES:1]        vld_pipe;
  logic                   s1_hit;
  logic [ROW_W-1:0]       s1_row, s1_col;
  logic [SHAPE_W-1:0]     s1_shape;
  logic [X_WIDTH-1:0]     s1_x;
  logic [Y_WIDTH-1:0]     s1_y;
  logic [DOT_WIDTH-1:0]   rom_row;

  // Shape is captured in stage 1 so a frame_start behind an in-flight
  // pixel cannot change which table it reads. Scale is already folded
  // into s1_row/s1_col.
  dot_shape_rom u_rom (
    .shape   (s1_shape),
    .row     (s1_row),
    .pattern (rom_row)
  );

  // Two-stage pipeline; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_hit   <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_shape <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      out_on   <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
      s1_hit   <= hit_n;
      s1_row   <= row_n;
      s1_col   <= col_n;
      s1_shape <= act_attr.shape;
      s1_x     <= pix_x;
      s1_y     <= pix_y;
      out_on   <= vld_pipe[1] && s1_hit && rom_row[3'd7 - s1_col];
      out_x    <= s1_x;
      out_y    <= s1_y;
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_dot_sprite_renderer.sv
// Self-checking bench: directed vector table, hand sequences for frame
// boundary cases, and randomized traffic against a pixel-level model.
module tb_dot_sprite_renderer;

  localparam int XW = 11;
  localparam int YW = 10;
  localparam int MS = 2;   // max scale exponent under test
  localparam int BF = 1;   // blink half-period log2

  logic          clk = 1'b0;
  logic          reset, frame_start, pix_valid, desc_load, desc_blink, desc_visible;
  logic [XW-1:0] pix_x, desc_x, out_x;
  logic [YW-1:0] pix_y, desc_y, out_y;
  logic [1:0]    desc_shape, desc_scale;
  logic          out_valid, out_on;

  always #5 clk = ~clk;

  dot_sprite_renderer #(.X_WIDTH(XW), .Y_WIDTH(YW), .MAX_SCALE_LOG2(MS),
                        .BLINK_FRAMES_LOG2(BF)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .desc_load(desc_load), .desc_x(desc_x),
    .desc_y(desc_y), .desc_shape(desc_shape), .desc_scale(desc_scale),
    .desc_blink(desc_blink), .desc_visible(desc_visible), .out_valid(out_valid),
    .out_on(out_on), .out_x(out_x), .out_y(out_y));

  int total = 0;
  int bad   = 0;

  typedef struct { int x; int y; int shape; int scale; int blink; int vis; } mdesc_t;
  typedef struct { bit v; bit on; int x; int y; } exp_t;
  typedef struct { int ox; int oy; int shape; int scale; int px; int py; int vis; bit exp; } vec_t;

  byte unsigned rom [4][8] = '{
    '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C},
    '{8'h3C, 8'h42, 8'h81, 8'h81, 8'h81, 8'h81, 8'h42, 8'h3C},
    '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18},
    '{8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF}};

  mdesc_t m_pend, m_act;
  int     m_cnt;
  exp_t   e1, e2;
  vec_t   vecs[$];

  // Is pixel (x,y) lit by descriptor d with frame counter cnt?
  function automatic bit model_on(int x, int y, mdesc_t d, int cnt);
    int sc, e, ddx, ddy;
    byte unsigned r;
    if (d.vis == 0) return 1'b0;
    if (d.blink != 0 && ((cnt >> BF) & 1) == 1) return 1'b0;
    sc  = (d.scale > MS) ? MS : d.scale;
    e   = 8 << sc;
    ddx = x - d.x;
    ddy = y - d.y;
    if (ddx < 0 || ddy < 0 || ddx >= e || ddy >= e) return 1'b0;
    r = rom[d.shape][ddy >> sc];
    return r[7 - (ddx >> sc)];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One clock: predict the pixel entering now, advance the model, compare
  // the DUT outputs with the prediction made two clocks earlier.
  task automatic tick();
    exp_t   cur;
    mdesc_t inc;
    cur.v  = pix_valid;
    cur.on = pix_valid && model_on(int'(pix_x), int'(pix_y), m_act, m_cnt);
    cur.x  = int'(pix_x);
    cur.y  = int'(pix_y);
    inc    = '{int'(desc_x), int'(desc_y), int'(desc_shape), int'(desc_scale),
               int'(desc_blink), int'(desc_visible)};
    @(posedge clk);
    #1;
    if (reset) begin
      m_pend = '{default: 0};
      m_act  = '{default: 0};
      m_cnt  = 0;
      e1     = '{default: 0};
      e2     = '{default: 0};
    end else begin
      if (frame_start) begin
        m_cnt = (m_cnt + 1) % (2 << BF);
        m_act = desc_load ? inc : m_pend;
      end
      if (desc_load) m_pend = inc;
      e2 = e1;
      e1 = cur;
    end
    total++;
    if ({out_valid, out_on, out_x, out_y} !== {e2.v, e2.on, XW'(e2.x), YW'(e2.y)}) begin
      bad++;
      $display("FAIL pipe got v=%0b on=%0b x=%0d y=%0d want v=%0b on=%0b x=%0d y=%0d",
               out_valid, out_on, out_x, out_y, e2.v, e2.on, e2.x, e2.y);
    end
  endtask

  task automatic set_desc(input int ox, input int oy, input int shp, input int sc,
                          input int bl, input int vis);
    desc_x       = XW'(ox);
    desc_y       = YW'(oy);
    desc_shape   = 2'(shp);
    desc_scale   = 2'(sc);
    desc_blink   = bl[0];
    desc_visible = vis[0];
  endtask

  // Load a descriptor straight into active via the load/frame_start bypass.
  task automatic load_now(input int ox, input int oy, input int shp, input int sc,
                          input int bl, input int vis);
    set_desc(ox, oy, shp, sc, bl, vis);
    desc_load = 1'b1; frame_start = 1'b1; pix_valid = 1'b0;
    tick();
    desc_load = 1'b0; frame_start = 1'b0;
  endtask

  // Send one pixel and wait for it to reach the output.
  task automatic probe(input int px, input int py, input string name, input bit want);
    pix_valid = 1'b1; pix_x = XW'(px); pix_y = YW'(py);
    tick();
    pix_valid = 1'b0;
    tick();
    chk(name, {30'd0, out_valid, out_on}, {30'd0, 1'b1, want});
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; desc_load = 1'b0;
    pix_valid = 1'b1; pix_x = 11'd5; pix_y = 10'd5;
    set_desc(0, 0, 0, 0, 0, 0);
    m_pend = '{default: 0}; m_act = '{default: 0}; m_cnt = 0;
    e1 = '{default: 0}; e2 = '{default: 0};

    // Reset held with pixels arriving, then release.
    repeat (3) tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_xy", {11'd0, out_x, out_y}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("rel_c2_valid", {31'd0, out_valid}, 32'd1);
    pix_valid = 1'b0;
    tick(); tick();

    // Directed vector table.
    vecs.push_back('{100, 50, 0, 0, 101, 50, 1, 1'b0});
    vecs.push_back('{100, 50, 0, 0, 102, 50, 1, 1'b1});
    vecs.push_back('{100, 50, 0, 0, 105, 50, 1, 1'b1});
    vecs.push_back('{100, 50, 0, 0, 106, 50, 1, 1'b0});
    vecs.push_back('{100, 50, 0, 0, 101, 51, 1, 1'b1});
    vecs.push_back('{100, 50, 0, 2, 107, 50, 1, 1'b0});
    vecs.push_back('{100, 50, 0, 2, 108, 50, 1, 1'b1});
    vecs.push_back('{100, 50, 0, 2, 123, 50, 1, 1'b1});
    vecs.push_back('{100, 50, 0, 2, 124, 50, 1, 1'b0});
    vecs.push_back('{100, 50, 0, 2, 100, 50, 1, 1'b0});
    vecs.push_back('{100, 50, 0, 2, 100, 58, 1, 1'b1});
    vecs.push_back('{0, 0, 1, 0, 0, 3, 1, 1'b1});
    vecs.push_back('{0, 0, 1, 0, 1, 3, 1, 1'b0});
    vecs.push_back('{0, 0, 1, 0, 7, 3, 1, 1'b1});
    vecs.push_back('{0, 0, 1, 0, 8, 3, 1, 1'b0});
    vecs.push_back('{0, 0, 3, 3, 31, 0, 1, 1'b1});
    vecs.push_back('{0, 0, 3, 3, 32, 0, 1, 1'b0});
    vecs.push_back('{0, 0, 3, 3, 0, 31, 1, 1'b1});
    vecs.push_back('{0, 0, 3, 3, 0, 32, 1, 1'b0});
    vecs.push_back('{10, 20, 2, 1, 16, 20, 1, 1'b1});
    vecs.push_back('{10, 20, 2, 1, 14, 20, 1, 1'b0});
    vecs.push_back('{10, 20, 2, 1, 10, 26, 1, 1'b1});
    vecs.push_back('{2040, 0, 3, 0, 2047, 0, 1, 1'b1});
    vecs.push_back('{2040, 0, 3, 0, 0, 0, 1, 1'b0});
    vecs.push_back('{2040, 0, 3, 0, 2040, 7, 1, 1'b1});
    vecs.push_back('{100, 50, 0, 0, 103, 51, 0, 1'b0});
    foreach (vecs[i]) begin
      load_now(vecs[i].ox, vecs[i].oy, vecs[i].shape, vecs[i].scale, 0, vecs[i].vis);
      probe(vecs[i].px, vecs[i].py, $sformatf("vec%0d", i), vecs[i].exp);
    end

    // Mid-frame load stays pending until the next frame_start.
    load_now(100, 50, 0, 0, 0, 1);
    set_desc(200, 50, 0, 0, 0, 1);
    desc_load = 1'b1; tick(); desc_load = 1'b0;
    probe(103, 50, "midload_old", 1'b1);
    probe(203, 50, "midload_new_dark", 1'b0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    probe(203, 50, "fs_new_lit", 1'b1);
    probe(103, 50, "fs_old_dark", 1'b0);
    load_now(300, 50, 0, 0, 0, 1);
    probe(303, 50, "bypass_lit", 1'b1);

    // Pixel coincident with frame_start uses the outgoing descriptor.
    load_now(100, 50, 0, 0, 0, 1);
    pix_valid = 1'b1; pix_x = 11'd103; pix_y = 10'd50;
    set_desc(500, 50, 0, 0, 0, 1);
    desc_load = 1'b1; frame_start = 1'b1;
    tick();
    pix_valid = 1'b0; desc_load = 1'b0; frame_start = 1'b0;
    tick();
    chk("fs_coincident", {31'd0, out_on}, 32'd1);

    // Pixel in stage 1 keeps its shape across a frame_start.
    load_now(0, 0, 0, 0, 0, 1);
    pix_valid = 1'b1; pix_x = 11'd1; pix_y = 10'd1;
    tick();
    pix_valid = 1'b0;
    set_desc(0, 0, 3, 0, 0, 1);
    desc_load = 1'b1; frame_start = 1'b1;
    tick();
    desc_load = 1'b0; frame_start = 1'b0;
    chk("shape_tagged", {31'd0, out_on}, 32'd1);
    probe(1, 1, "shape_box_after", 1'b0);

    // Blink: counter restarts at reset; dark while counter MSB is set.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int f = 1; f <= 6; f++) begin
      if (f == 1) begin
        load_now(0, 0, 0, 0, 1, 1);
      end else begin
        frame_start = 1'b1; tick(); frame_start = 1'b0;
      end
      probe(3, 0, $sformatf("blink_f%0d", f), ((f % 4) < 2));
    end

    // Random traffic, pixels clustered near the active sprite.
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      frame_start = ($urandom_range(0, 39) == 0);
      desc_load   = ($urandom_range(0, 14) == 0);
      set_desc($urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 7) != 0));
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_x     = XW'(m_act.x + $urandom_range(0, 80) - 8);
      pix_y     = YW'(m_act.y + $urandom_range(0, 80) - 8);
      tick();
    end
    reset = 1'b0; frame_start = 1'b0; desc_load = 1'b0; pix_valid = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
